// File: rtl/color_slice.sv
// Pixel register slice: CN x CW channels through a 2-entry skid buffer, optional per-pixel channel reversal (COLOR_SLICE_CNT_EN adds an output transfer counter).
// Latency: 1 cycle from input accept to m_data when the slice is EMPTY or draining in the same cycle.
// Backpressure: s_ready is registered and drops only when both entries are full; m_data holds while m_valid & !m_ready.
module color_slice #(
    parameter int CN    = 3,
    parameter int CW    = 8,
    parameter int CNT_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [CN*CW-1:0]    s_data,
    input  logic                s_swap,
    output logic                m_valid,
    input  logic                m_ready,
    output logic [CN*CW-1:0]    m_data,
    output logic [CNT_W-1:0]    m_cnt
);

    localparam int DW = CN * CW;

    // ST_INIT keeps s_ready low for the first edge after reset release.
    typedef enum logic [1:0] {
        ST_INIT,
        ST_EMPTY,
        ST_ONE,
        ST_FULL
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [DW-1:0]   main_dat;
    logic [DW-1:0]   main_nxt;
    logic [DW-1:0]   skid_dat;
    logic [DW-1:0]   skid_nxt;
    logic [DW-1:0]   cap_dat;
    logic            in_xfer;
    logic            out_xfer;
    logic            s_ready_nxt;
    logic            m_valid_nxt;

    assign in_xfer  = s_valid & s_ready;
    assign out_xfer = m_valid & m_ready;
    assign m_data   = main_dat;

    always_comb begin
        cap_dat = s_data;
        if (s_swap) begin
            for (int k = 0; k < CN; k++) begin
                cap_dat[k*CW +: CW] = s_data[(CN-1-k)*CW +: CW];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        main_nxt  = main_dat;
        skid_nxt  = skid_dat;
        case (state)
            ST_INIT: begin
                state_nxt = ST_EMPTY;
            end
            ST_EMPTY: begin
                if (in_xfer) begin
                    main_nxt  = cap_dat;
                    state_nxt = ST_ONE;
                end
            end
            ST_ONE: begin
                case ({in_xfer, out_xfer})
                    2'b11: main_nxt = cap_dat;
                    2'b10: begin
                        skid_nxt  = cap_dat;
                        state_nxt = ST_FULL;
                    end
                    2'b01: state_nxt = ST_EMPTY;
                    default: state_nxt = ST_ONE;
                endcase
            end
            ST_FULL: begin
                if (out_xfer) begin
                    main_nxt  = skid_dat;
                    state_nxt = ST_ONE;
                end
            end
            default: state_nxt = ST_EMPTY;
        endcase
        // Handshake outputs are decoded from the next state so they leave a flop.
        m_valid_nxt = (state_nxt == ST_ONE) || (state_nxt == ST_FULL);
        s_ready_nxt = (state_nxt == ST_EMPTY) || (state_nxt == ST_ONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_INIT;
            main_dat <= '0;
            skid_dat <= '0;
            m_valid  <= 1'b0;
            s_ready  <= 1'b0;
        end else begin
            state    <= state_nxt;
            main_dat <= main_nxt;
            skid_dat <= skid_nxt;
            m_valid  <= m_valid_nxt;
            s_ready  <= s_ready_nxt;
        end
    end

`ifdef COLOR_SLICE_CNT_EN
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (out_xfer) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign m_cnt = cnt;
`else
    assign m_cnt = '0;
`endif

endmodule

// File: tb/tb_color_slice.sv
// Directed and random checks of color_slice: reset, streaming, swap, backpressure, counter, random ordering.
module tb_color_slice;

`ifdef COLOR_SLICE_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    localparam int NPIX = 10000;

    logic        clk;
    logic        rst_n;

    logic        a_s_valid, a_s_ready, a_s_swap, a_m_valid, a_m_ready;
    logic [23:0] a_s_data, a_m_data;
    logic [3:0]  a_m_cnt;

    logic        b_s_valid, b_s_ready, b_s_swap, b_m_valid, b_m_ready;
    logic [39:0] b_s_data, b_m_data;
    logic [15:0] b_m_cnt;

    int total = 0;
    int bad   = 0;

    color_slice #(.CN(3), .CW(8), .CNT_W(4)) dut_a (
        .clk     (clk),
        .rst_n   (rst_n),
        .s_valid (a_s_valid),
        .s_ready (a_s_ready),
        .s_data  (a_s_data),
        .s_swap  (a_s_swap),
        .m_valid (a_m_valid),
        .m_ready (a_m_ready),
        .m_data  (a_m_data),
        .m_cnt   (a_m_cnt)
    );

    color_slice #(.CN(4), .CW(10), .CNT_W(16)) dut_b (
        .clk     (clk),
        .rst_n   (rst_n),
        .s_valid (b_s_valid),
        .s_ready (b_s_ready),
        .s_data  (b_s_data),
        .s_swap  (b_s_swap),
        .m_valid (b_m_valid),
        .m_ready (b_m_ready),
        .m_data  (b_m_data),
        .m_cnt   (b_m_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [39:0] swap4(input logic [39:0] d);
        return {d[9:0], d[19:10], d[29:20], d[39:30]};
    endfunction

    function automatic logic [3:0] ecnt(input int v);
        return CNT_EN ? 4'(v) : 4'd0;
    endfunction

    initial begin
        logic [39:0] exp_px;
        logic [39:0] held;
        logic        hold_prev;
        logic        in_hs, out_hs;
        int          sent, rcvd, cyc;
        logic [39:0] q[$];

        rst_n = 1'b0;
        a_s_valid = 1'b0; a_s_swap = 1'b0; a_s_data = '0; a_m_ready = 1'b1;
        b_s_valid = 1'b0; b_s_swap = 1'b0; b_s_data = '0; b_m_ready = 1'b0;

        // Power-on reset
        #1;
        check("por_m_valid", a_m_valid, 1'b0);
        check("por_s_ready", a_s_ready, 1'b0);
        check("por_m_data",  a_m_data, 24'h0);
        check("por_m_cnt",   a_m_cnt, 4'h0);
        tick;
        tick;
        rst_n = 1'b1;
        #1;
        check("rel_s_ready_pre", a_s_ready, 1'b0);
        tick;
        check("rel_s_ready_post", a_s_ready, 1'b1);
        check("rel_m_valid",      a_m_valid, 1'b0);

        // Streaming 16 pixels, one per cycle
        for (int i = 0; i < 16; i++) begin
            a_s_valid = 1'b1;
            a_s_data  = 24'(i * 24'h010101);
            tick;
            check("str_m_valid", a_m_valid, 1'b1);
            check("str_s_ready", a_s_ready, 1'b1);
            check("str_m_data",  a_m_data, 24'(i * 24'h010101));
            check("str_m_cnt",   a_m_cnt, ecnt(i));
        end
        a_s_valid = 1'b0;
        tick;
        check("str_drain_valid", a_m_valid, 1'b0);
        check("str_drain_cnt",   a_m_cnt, ecnt(16));

        // Channel swap
        a_s_valid = 1'b1; a_s_data = 24'h030201; a_s_swap = 1'b1;
        tick;
        check("swap1_data", a_m_data, 24'h010203);
        a_s_swap = 1'b0;
        tick;
        check("swap0_data", a_m_data, 24'h030201);
        check("cnt_17th",   a_m_cnt, ecnt(1));
        a_s_valid = 1'b0;
        tick;
        check("swap_drain_valid", a_m_valid, 1'b0);
        check("swap_drain_cnt",   a_m_cnt, ecnt(2));

        // Backpressure: A, B fill the slice, C must wait
        a_m_ready = 1'b0;
        a_s_valid = 1'b1; a_s_data = 24'hA1A2A3;
        tick;
        check("bp_a_data",    a_m_data, 24'hA1A2A3);
        check("bp_a_s_ready", a_s_ready, 1'b1);
        a_s_data = 24'hB1B2B3;
        tick;
        check("bp_full_s_ready", a_s_ready, 1'b0);
        check("bp_full_data",    a_m_data, 24'hA1A2A3);
        a_s_data = 24'hC1C2C3;
        tick;
        check("bp_c_held_s_ready", a_s_ready, 1'b0);
        check("bp_c_held_data",    a_m_data, 24'hA1A2A3);
        tick;
        check("bp_stable_valid", a_m_valid, 1'b1);
        check("bp_stable_data",  a_m_data, 24'hA1A2A3);
        a_m_ready = 1'b1;
        tick;
        check("bp_out_b",       a_m_data, 24'hB1B2B3);
        check("bp_out_b_ready", a_s_ready, 1'b1);
        check("bp_cnt_a",       a_m_cnt, ecnt(3));
        tick;
        check("bp_out_c", a_m_data, 24'hC1C2C3);
        a_s_valid = 1'b0;
        tick;
        check("bp_empty_valid", a_m_valid, 1'b0);
        check("bp_cnt_c",       a_m_cnt, ecnt(5));

        // Asynchronous reset while FULL
        a_m_ready = 1'b0;
        a_s_valid = 1'b1; a_s_data = 24'hD1D2D3;
        tick;
        a_s_data = 24'hE1E2E3;
        tick;
        check("rst_pre_full", a_s_ready, 1'b0);
        a_s_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("rst_m_valid", a_m_valid, 1'b0);
        check("rst_s_ready", a_s_ready, 1'b0);
        check("rst_m_data",  a_m_data, 24'h0);
        check("rst_m_cnt",   a_m_cnt, 4'h0);
        #1;
        rst_n = 1'b1;
        #1;
        check("rst_rel_s_ready_pre", a_s_ready, 1'b0);
        tick;
        check("rst_rel_s_ready", a_s_ready, 1'b1);
        check("rst_rel_m_valid", a_m_valid, 1'b0);
        a_m_ready = 1'b1;

        // Random handshakes on the CN=4, CW=10 instance
        sent = 0; rcvd = 0; cyc = 0; hold_prev = 1'b0; held = '0;
        while (rcvd < NPIX && cyc < 60000) begin
            b_m_ready = ($urandom_range(0, 3) != 0);
            if (!b_s_valid && sent < NPIX && $urandom_range(0, 3) != 0) begin
                b_s_data  = 40'({$urandom(), $urandom()});
                b_s_swap  = 1'($urandom_range(0, 1));
                b_s_valid = 1'b1;
            end
            @(negedge clk);
            if (hold_prev) begin
                check("rnd_hold_valid", b_m_valid, 1'b1);
                check("rnd_hold_data",  b_m_data, held);
            end
            in_hs  = b_s_valid && b_s_ready;
            out_hs = b_m_valid && b_m_ready;
            hold_prev = b_m_valid && !b_m_ready;
            held      = b_m_data;
            if (out_hs) begin
                if (q.size() == 0) begin
                    check("rnd_extra_pixel", b_m_data, 64'hDEAD);
                end else begin
                    exp_px = q.pop_front();
                    check("rnd_data", b_m_data, exp_px);
                end
                rcvd++;
            end
            if (in_hs) begin
                q.push_back(b_s_swap ? swap4(b_s_data) : b_s_data);
                sent++;
            end
            tick;
            cyc++;
            if (in_hs) b_s_valid = 1'b0;
        end
        b_s_valid = 1'b0;
        b_m_ready = 1'b0;
        check("rnd_rcvd_count", rcvd, NPIX);
        check("rnd_queue_left", q.size(), 0);
        check("rnd_m_cnt", b_m_cnt, CNT_EN ? 16'(NPIX) : 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
